// File: rtl/traffic_pkg.sv
// Shared signalling definitions for the traffic light controller and its safety monitor.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_INVALID      = 3'd1,
        FC_CONFLICT     = 3'd2,
        FC_SEQUENCE     = 3'd3,
        FC_SHORT_YELLOW = 3'd4
    } fault_code_e;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } mon_state_e;

    function automatic logic is_valid(input logic [2:0] code);
        return (code == RED) || (code == YELLOW) || (code == GREEN);
    endfunction

endpackage

// File: rtl/traffic_signal_monitor_if.sv
// Lamp-code bus between the controller, the safety monitor and the lamp drivers.
interface traffic_signal_monitor_if;

    logic [2:0] north_in;
    logic [2:0] east_in;
    logic [2:0] south_in;
    logic [2:0] west_in;
    logic       clear_fault;
    logic [2:0] lamp_north;
    logic [2:0] lamp_east;
    logic [2:0] lamp_south;
    logic [2:0] lamp_west;
    logic       fault;
    logic [2:0] fault_code;

    modport master (
        output north_in, east_in, south_in, west_in, clear_fault,
        input  lamp_north, lamp_east, lamp_south, lamp_west, fault, fault_code
    );

    modport slave (
        input  north_in, east_in, south_in, west_in, clear_fault,
        output lamp_north, lamp_east, lamp_south, lamp_west, fault, fault_code
    );

endinterface

// File: rtl/light_channel_checker.sv
// Per-approach history and rule flags: invalid code, illegal transition, short yellow.
module light_channel_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code,
    input  logic       restart,
    output logic       invalid,
    output logic       seq_err,
    output logic       short_yellow,
    output logic       non_red
);

    localparam logic [3:0] MIN_Y = 4'(MIN_YELLOW);

    logic [2:0] prev;
    logic [3:0] ycnt;

    // History keeps tracking in failsafe; only an accepted clear rewinds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= RED;
            ycnt <= '0;
        end else if (restart) begin
            prev <= RED;
            ycnt <= '0;
        end else begin
            prev <= code;
            if (code == YELLOW) begin
                ycnt <= (ycnt == 4'd15) ? ycnt : ycnt + 4'd1;
            end else begin
                ycnt <= '0;
            end
        end
    end

    assign invalid      = !is_valid(code);
    assign non_red      = (code != RED);
    assign seq_err      = ((prev == GREEN)  && (code == RED))    ||
                          ((prev == RED)    && (code == YELLOW)) ||
                          ((prev == YELLOW) && (code == GREEN));
    assign short_yellow = (prev == YELLOW) && (code == RED) && (ycnt < MIN_Y);

endmodule

// File: rtl/traffic_signal_monitor.sv
// Safety monitor: registers legal lamp codes through, latches the first fault and flashes red.
module traffic_signal_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2,
    parameter int FLASH_HALF = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    traffic_signal_monitor_if.slave  bus
);

    localparam logic [7:0] HALF_LAST = 8'(FLASH_HALF - 1);

    logic [2:0]  code [4];
    logic [3:0]  invalid;
    logic [3:0]  seq_err;
    logic [3:0]  short_yellow;
    logic [3:0]  non_red;
    logic        all_red;
    logic        conflict;
    logic        restart;
    fault_code_e detected;

    mon_state_e  state;
    logic [7:0]  flash_cnt;
    logic [2:0]  lamp [4];
    logic        fault;
    fault_code_e fault_code;

    assign code[0] = bus.north_in;
    assign code[1] = bus.east_in;
    assign code[2] = bus.south_in;
    assign code[3] = bus.west_in;

    for (genvar i = 0; i < 4; i++) begin : g_chk
        light_channel_checker #(.MIN_YELLOW(MIN_YELLOW)) u_chk (
            .clk          (clk),
            .rst_n        (rst_n),
            .code         (code[i]),
            .restart      (restart),
            .invalid      (invalid[i]),
            .seq_err      (seq_err[i]),
            .short_yellow (short_yellow[i]),
            .non_red      (non_red[i])
        );
    end

    assign all_red  = (non_red == 4'b0000);
    assign conflict = ((non_red & (non_red - 4'd1)) != 4'b0000);
    assign restart  = (state != NORMAL) && bus.clear_fault && all_red;

    always_comb begin
        detected = FC_NONE;
        if (|invalid)           detected = FC_INVALID;
        else if (conflict)      detected = FC_CONFLICT;
        else if (|seq_err)      detected = FC_SEQUENCE;
        else if (|short_yellow) detected = FC_SHORT_YELLOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            flash_cnt  <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            for (int i = 0; i < 4; i++) lamp[i] <= RED;
        end else begin
            case (state)
                NORMAL: begin
                    if (detected != FC_NONE) begin
                        state      <= FLASH_ON;
                        flash_cnt  <= '0;
                        fault      <= 1'b1;
                        fault_code <= detected;
                        for (int i = 0; i < 4; i++) lamp[i] <= RED;
                    end else begin
                        for (int i = 0; i < 4; i++) lamp[i] <= code[i];
                    end
                end
                FLASH_ON, FLASH_OFF: begin
                    if (restart) begin
                        state      <= NORMAL;
                        flash_cnt  <= '0;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        for (int i = 0; i < 4; i++) lamp[i] <= RED;
                    end else if (flash_cnt == HALF_LAST) begin
                        // Toggle phase: the lamps show the phase being entered.
                        state     <= (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                        flash_cnt <= '0;
                        for (int i = 0; i < 4; i++) lamp[i] <= (state == FLASH_ON) ? DARK : RED;
                    end else begin
                        flash_cnt <= flash_cnt + 8'd1;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

    assign bus.lamp_north = lamp[0];
    assign bus.lamp_east  = lamp[1];
    assign bus.lamp_south = lamp[2];
    assign bus.lamp_west  = lamp[3];
    assign bus.fault      = fault;
    assign bus.fault_code = fault_code;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: directed scenarios and random traffic against a rule-level model.
module tb_traffic_signal_monitor;
    import traffic_pkg::*;

    localparam int MIN_YELLOW = 2;
    localparam int FLASH_HALF = 4;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk = 1'b0;
    logic rst_n;

    traffic_signal_monitor_if bus();

    traffic_signal_monitor #(.MIN_YELLOW(MIN_YELLOW), .FLASH_HALF(FLASH_HALF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Rule-level model: run lengths of yellow, time since fault entry, phase by division.
    logic [2:0] m_prev [4];
    int         m_run  [4];
    logic [2:0] m_lamp [4];
    bit         m_fail;
    int         m_elapsed;
    logic       m_fault;
    logic [2:0] m_code;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = R;
            m_run[i]  = 0;
            m_lamp[i] = R;
        end
        m_fail    = 1'b0;
        m_elapsed = 0;
        m_fault   = 1'b0;
        m_code    = 3'd0;
    endtask

    task automatic model_edge(input logic [2:0] c0, c1, c2, c3, input logic clr);
        logic [2:0] c [4];
        int nonred;
        bit inv, seq, shrt;
        int code;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        nonred = 0; inv = 0; seq = 0; shrt = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(c[i] inside {R, Y, G})) inv = 1;
            if (c[i] != R) nonred++;
            if ((m_prev[i] == G && c[i] == R) || (m_prev[i] == R && c[i] == Y) ||
                (m_prev[i] == Y && c[i] == G)) seq = 1;
            if (m_prev[i] == Y && c[i] == R && m_run[i] < MIN_YELLOW) shrt = 1;
        end
        code = inv ? 1 : (nonred >= 2) ? 2 : seq ? 3 : shrt ? 4 : 0;
        for (int i = 0; i < 4; i++) begin
            m_run[i]  = (c[i] == Y) ? m_run[i] + 1 : 0;
            m_prev[i] = c[i];
        end
        if (!m_fail) begin
            if (code != 0) begin
                m_fail = 1'b1; m_elapsed = 0; m_fault = 1'b1; m_code = 3'(code);
                for (int i = 0; i < 4; i++) m_lamp[i] = R;
            end else begin
                for (int i = 0; i < 4; i++) m_lamp[i] = c[i];
            end
        end else if (clr && nonred == 0) begin
            m_fail = 1'b0; m_fault = 1'b0; m_code = 3'd0;
            for (int i = 0; i < 4; i++) begin
                m_lamp[i] = R; m_prev[i] = R; m_run[i] = 0;
            end
        end else begin
            m_elapsed++;
            for (int i = 0; i < 4; i++)
                m_lamp[i] = (((m_elapsed / FLASH_HALF) % 2) == 0) ? R : 3'b000;
        end
    endtask

    task automatic step(input logic [2:0] n, e, s, w, input logic clr);
        bus.north_in = n; bus.east_in = e; bus.south_in = s; bus.west_in = w;
        bus.clear_fault = clr;
        @(posedge clk);
        model_edge(n, e, s, w, clr);
        @(negedge clk);
    endtask

    function automatic logic [15:0] observed();
        return {bus.lamp_north, bus.lamp_east, bus.lamp_south, bus.lamp_west, bus.fault, bus.fault_code};
    endfunction

    function automatic logic [15:0] expected();
        return {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], m_fault, m_code};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.north_in = G; bus.east_in = G; bus.south_in = R; bus.west_in = R;
        bus.clear_fault = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (observed() !== 16'b100_100_100_100_0_000) begin
            errors++; $display("FAIL reset_hold got %h want %h", observed(), 16'b100_100_100_100_0_000);
        end
        bus.north_in = R; bus.east_in = R;
        rst_n = 1'b1;
        step(R, R, R, R, 1'b0);
        checks++;
        if (observed() !== expected()) begin
            errors++; $display("FAIL reset_release got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_legal_cycle();
        logic [2:0] seq [10] = '{G, G, G, G, G, Y, Y, R, R, R};
        for (int k = 0; k < 10; k++) begin
            step(seq[k], R, R, R, 1'b0);
            checks++;
            if (observed() !== expected() || bus.lamp_north !== seq[k] || bus.fault !== 1'b0) begin
                errors++; $display("FAIL legal_cycle step %0d got %h want %h", k, observed(), expected());
            end
        end
    endtask

    task automatic test_short_yellow();
        step(G, R, R, R, 1'b0);
        step(G, R, R, R, 1'b0);
        step(Y, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        checks++;
        if (bus.fault !== 1'b1 || bus.fault_code !== 3'd4 || bus.lamp_north !== R) begin
            errors++; $display("FAIL short_yellow_entry got %h want fault 1 code 4", observed());
        end
        for (int k = 1; k <= 17; k++) begin
            step(R, R, R, R, 1'b0);
            checks++;
            if (observed() !== expected() || bus.lamp_east !== (((k / 4) % 2 == 0) ? R : 3'b000)) begin
                errors++; $display("FAIL flash_pattern cycle %0d got %h want %h", k, observed(), expected());
            end
        end
        step(R, R, R, R, 1'b1);
        checks++;
        if (observed() !== expected() || bus.fault !== 1'b0) begin
            errors++; $display("FAIL short_yellow_clear got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_conflict_invalid();
        step(G, G, R, R, 1'b0);
        checks++;
        if (observed() !== expected() || bus.fault_code !== 3'd2) begin
            errors++; $display("FAIL conflict got %h want %h", observed(), expected());
        end
        step(R, R, R, R, 1'b1);
        checks++;
        if (observed() !== expected()) begin
            errors++; $display("FAIL conflict_clear got %h want %h", observed(), expected());
        end
        step(3'b011, G, R, R, 1'b0);
        checks++;
        if (observed() !== expected() || bus.fault_code !== 3'd1) begin
            errors++; $display("FAIL invalid_priority got %h want %h", observed(), expected());
        end
        step(R, R, R, R, 1'b1);
        checks++;
        if (observed() !== expected()) begin
            errors++; $display("FAIL invalid_clear got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_sequence_clear();
        step(G, R, R, R, 1'b0);
        step(G, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        checks++;
        if (observed() !== expected() || bus.fault_code !== 3'd3) begin
            errors++; $display("FAIL sequence got %h want %h", observed(), expected());
        end
        step(G, R, R, R, 1'b1);
        step(G, R, R, R, 1'b1);
        checks++;
        if (observed() !== expected() || bus.fault !== 1'b1 || bus.fault_code !== 3'd3) begin
            errors++; $display("FAIL clear_ignored got %h want %h", observed(), expected());
        end
        step(R, R, R, R, 1'b1);
        checks++;
        if (observed() !== expected() || bus.fault !== 1'b0 || bus.fault_code !== 3'd0) begin
            errors++; $display("FAIL clear_accepted got %h want %h", observed(), expected());
        end
        step(G, R, R, R, 1'b0);
        checks++;
        if (observed() !== expected() || bus.lamp_north !== G) begin
            errors++; $display("FAIL first_after_clear got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_failsafe_ignore_and_reset();
        step(G, R, R, R, 1'b0);
        step(Y, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        for (int k = 0; k < 3; k++) step(G, G, R, R, 1'b0);
        checks++;
        if (observed() !== expected() || bus.fault_code !== 3'd4) begin
            errors++; $display("FAIL sticky_code got %h want %h", observed(), expected());
        end
        step(R, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (observed() !== 16'b100_100_100_100_0_000) begin
            errors++; $display("FAIL async_reset got %h want %h", observed(), 16'b100_100_100_100_0_000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(G, R, R, R, 1'b0);
        checks++;
        if (observed() !== expected() || bus.lamp_north !== G) begin
            errors++; $display("FAIL after_reset got %h want %h", observed(), expected());
        end
        step(Y, R, R, R, 1'b0);
        step(Y, R, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
    endtask

    task automatic test_controller();
        logic [11:0] q [$];
        logic [2:0]  c [4];
        int a = 1;
        while (q.size() < 100) begin
            int g  = $urandom_range(1, 6);
            int yl = $urandom_range(MIN_YELLOW, MIN_YELLOW + 2);
            int rl = $urandom_range(1, 2);
            for (int k = 0; k < g + yl + rl; k++) begin
                for (int i = 0; i < 4; i++) c[i] = R;
                if (k < g) c[a] = G;
                else if (k < g + yl) c[a] = Y;
                q.push_back({c[0], c[1], c[2], c[3]});
            end
            a = (a + 1) % 4;
        end
        for (int k = 0; k < 100; k++) begin
            step(q[k][11:9], q[k][8:6], q[k][5:3], q[k][2:0], 1'b0);
            checks++;
            if (observed() !== expected() || bus.fault !== 1'b0) begin
                errors++; $display("FAIL controller cycle %0d got %h want %h", k, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] c [4];
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                int r = $urandom_range(0, 11);
                c[i] = (r < 8) ? R : (r < 10) ? Y : (r < 11) ? G : 3'($urandom_range(0, 7));
            end
            step(c[0], c[1], c[2], c[3], ($urandom_range(0, 3) == 0));
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL random cycle %0d got %h want %h", k, observed(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_short_yellow();
        test_conflict_invalid();
        test_sequence_clear();
        test_failsafe_ignore_and_reset();
        test_controller();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

Safety stage directly downstream of `traffic_light_controller`. It samples the controller's four 3-bit lamp codes each cycle and checks them against the signalling rules. Legal codes pass through to the lamp drivers with one cycle of registration. Any violation latches a sticky fault and overrides all four approaches with flashing red until an operator clears it.

## Interface
- `MIN_YELLOW`, default 2: minimum consecutive YELLOW samples required before RED; range 1..15.
- `FLASH_HALF`, default 4: cycles per half-period of the failsafe flash; range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `north_in`, `east_in`, `south_in`, `west_in`  in  3 each  lamp codes from the controller: RED=100, YELLOW=010, GREEN=001.
- `clear_fault`  in  1  operator request to leave failsafe; level, sampled on each edge.
- `lamp_north`, `lamp_east`, `lamp_south`, `lamp_west`  out  3 each  registered lamp drive.
- `fault`  out  1  high while in failsafe.
- `fault_code`  out  3  first fault recorded:
  - 0 NONE
  - 1 INVALID (code not one-hot)
  - 2 CONFLICT (more than one approach non-RED)
  - 3 SEQUENCE (illegal transition)
  - 4 SHORT_YELLOW

## Operation
- FSM states:
  - NORMAL: lamps ← inputs.
  - FLASH_ON: all lamps 100.
  - FLASH_OFF: all lamps 000 (dark).
- Per-approach history register `prev`, reset to RED.
- Per-approach yellow counter `ycnt`, 4-bit:
  - resets to 0.
  - `ycnt` ← min(`ycnt`+1, 15) while the input is YELLOW.
  - `ycnt` ← 0 otherwise.
  - `ycnt` therefore counts consecutive YELLOW samples up to and including the current one.
- Checks are evaluated in NORMAL only, on every edge, against the current inputs and `prev`:
  - INVALID: any input not in {100, 010, 001}.
  - CONFLICT: two or more inputs ≠ RED.
  - SEQUENCE: any of GREEN→RED, RED→YELLOW, YELLOW→GREEN.
  - SHORT_YELLOW: YELLOW→RED with the stored `ycnt` < MIN_YELLOW.
  - Legal transitions: RED→GREEN, GREEN→YELLOW, YELLOW→RED, and hold.
- Simultaneous violations: priority INVALID > CONFLICT > SEQUENCE > SHORT_YELLOW. Only the highest is recorded; all approaches feed one code.
- On any violation in NORMAL:
  - next state FLASH_ON.
  - `fault` ← 1, `fault_code` ← the recorded code.
  - flash counter ← 0.
  - the violating sample is NOT passed to the lamps; lamps go 100 on that edge.
- FLASH_ON and FLASH_OFF alternate every FLASH_HALF cycles. The flash counter width is 8 bits and it wraps to 0 at each toggle.
- Further violations during failsafe are ignored; `fault_code` is sticky.
- Clearing the fault:
  - `clear_fault` high in either flash state with all four inputs == 100 moves the FSM to NORMAL.
  - On that edge: `fault` ← 0, `fault_code` ← 0, `prev` ← RED, `ycnt` ← 0, lamps ← 100.
  - If `clear_fault` is high while any input ≠ RED, it is ignored.
- In failsafe, `prev` and `ycnt` keep tracking the inputs, but no checks fire.

## Timing
- Reset values:
  - lamps 100.
  - `fault` 0, `fault_code` 0.
  - state NORMAL.
  - `prev` RED, `ycnt` 0, flash counter 0.
- Reset mid-failsafe returns immediately to NORMAL with the above values.
- Pass-through latency is 1 cycle: input sampled at edge k appears on the lamps after edge k.
- Fault latency is 1 cycle: a violating sample at edge k gives `fault`=1 and lamps 100 after edge k.
- First FLASH_OFF begins FLASH_HALF cycles after fault entry. Flash period is 2·FLASH_HALF.
- Clear latency is 1 cycle; the first checked sample is the one at the edge following the clear.

## Structure
- Package `traffic_pkg`:
  - RED/YELLOW/GREEN localparams.
  - `fault_code_e` enum.
  - `mon_state_e` enum.
  - shared with the controller.
- Sub-module `light_channel_checker`, instantiated ×4:
  - contains `prev`, `ycnt`, and the invalid/sequence/short-yellow flags for one approach.
  - the top level holds the conflict check, priority encoder, FSM and flash counter.

## Test plan
- Reset, then legal cycle N: GREEN 5, YELLOW 2, RED, others RED → lamps mirror inputs with 1-cycle lag; `fault`=0 throughout.
- MIN_YELLOW=2, N: GREEN → YELLOW 1 cycle → RED → `fault`=1 and `fault_code`=4 one cycle later; lamps 100 for 4 cycles, then 000 for 4, repeating.
- N=001 and E=001 together → `fault_code`=2. Also inject N=011 together with E conflicting → `fault_code`=1 (priority).
- N: GREEN→RED directly → code 3. Then `clear_fault`=1 while N=001 → ignored. Then all inputs 100 with `clear_fault`=1 → NORMAL next cycle, `fault_code`=0.
- In failsafe, inject a new conflict → `fault_code` unchanged. Assert `rst_n`=0 mid-flash → lamps 100, `fault`=0 immediately.
- Drive the real `traffic_light_controller` output for 100 cycles → `fault` never asserts.
